// File: rtl/minterm_scanner_pkg.sv
// Shared types and constants for the minterm scanner.
package minterm_scanner_pkg;

    localparam int N_VARS_DEF = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/minterm_scanner.sv
// Sweeps every input code through an external combinational function and
// streams out, over valid/ready, each code where the function is true.
// Also accumulates the number of accepted minterms for the sweep.
module minterm_scanner
    import minterm_scanner_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_VARS-1:0] fn_in,
    input  logic              fn_f,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_VARS-1:0] m_index,
    output logic [N_VARS:0]   count
);

    localparam logic [N_VARS-1:0] MAX = {N_VARS{1'b1}};

    state_t            state, state_nxt;
    logic [N_VARS-1:0] idx;
    logic              at_max;

    assign at_max  = (idx == MAX);
    assign fn_in   = idx;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    // m_valid is exactly "in EMIT": it is set on entry and cleared on handshake.
    assign m_valid = (state == S_EMIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the terminal probe at MAX never wraps idx.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PROBE;
            S_PROBE: begin
                if (fn_f)        state_nxt = S_EMIT;
                else if (at_max) state_nxt = S_DONE;
            end
            S_EMIT:  if (m_ready) state_nxt = at_max ? S_DONE : S_PROBE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Probe counter, captured minterm and accepted-minterm accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            m_index <= '0;
            count   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    idx   <= '0;
                    count <= '0;
                end
                S_PROBE: begin
                    if (fn_f)         m_index <= idx;
                    else if (!at_max) idx     <= idx + 1'b1;
                end
                S_EMIT: if (m_ready) begin
                    count <= count + 1'b1;
                    if (!at_max) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: attaches a few reference functions to
// fn_in/fn_f and checks the emitted minterm stream, count, done and timing.
module tb_minterm_scanner;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [N-1:0] fn_in;
    logic         fn_f;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_index;
    logic [N:0]   count;

    int compared = 0;
    int mismatched = 0;

    // Function select: 0 = sum-of-minterms form, 1 = truth-table form,
    // 2 = constant 0, 3 = constant 1.
    int fsel;

    logic [31:0] tt;

    int got[$];
    int ndone, ncyc, vseen;

    int exp16[$] = '{1, 3, 6, 10, 13, 14, 18, 19, 20, 21, 22, 24, 25, 28, 29, 31};
    int exp32[$];
    int exp0[$];

    minterm_scanner #(.N_VARS(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .fn_in   (fn_in),
        .fn_f    (fn_f),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_index (m_index),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Reference functions driving fn_f from fn_in.
    always_comb begin
        tt = 32'hB37C_644A;
        case (fsel)
            0:       fn_f = fn_in inside {5'd1, 5'd3, 5'd6, 5'd10, 5'd13, 5'd14, 5'd18, 5'd19,
                                          5'd20, 5'd21, 5'd22, 5'd24, 5'd25, 5'd28, 5'd29, 5'd31};
            1:       fn_f = tt[fn_in];
            2:       fn_f = 1'b0;
            default: fn_f = 1'b1;
        endcase
    end

    // Observe the stream on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got.push_back(int'(m_index));
            if (m_valid)            vseen++;
            if (done)               ndone++;
            if (busy && !done)      ncyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        got.delete();
        ndone = 0;
        ncyc  = 0;
        vseen = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep from start to the cycle after done.  stall_at >= 0 drops
    // m_ready for 5 cycles when that index is offered; spam re-pulses start
    // mid-sweep and in the done cycle.
    task automatic sweep(input string tag, input int stall_at, input bit spam);
        bit seen_done;
        clear_mon();
        seen_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (stall_at >= 0 && m_valid && m_ready && int'(m_index) == stall_at) begin
                m_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk($sformatf("%s stall m_index", tag), 32'(m_index), 32'(stall_at));
                    chk($sformatf("%s stall fn_in", tag), 32'(fn_in), 32'(stall_at));
                    chk($sformatf("%s stall m_valid", tag), 32'(m_valid), 32'd1);
                end
                m_ready = 1'b1;
            end
            start = (spam && (c % 7 == 3)) ? 1'b1 : 1'b0;
            tick();
        end
        chk($sformatf("%s done reached", tag), 32'(seen_done), 32'd1);
        start = spam;
        tick();
        start = 1'b0;
        chk($sformatf("%s busy after done", tag), 32'(busy), 32'd0);
        chk($sformatf("%s done single cycle", tag), 32'(done), 32'd0);
        repeat (3) tick();
        chk($sformatf("%s stays idle", tag), 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag, input int expq[$], input int cyc);
        chk($sformatf("%s stream length", tag), 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s m_index[%0d]", tag, i), 32'(got[i]), 32'(expq[i]));
        chk($sformatf("%s count", tag), 32'(count), 32'(expq.size()));
        chk($sformatf("%s done pulses", tag), 32'(ndone), 32'd1);
        chk($sformatf("%s sweep cycles", tag), 32'(ncyc), 32'(cyc));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp32.push_back(i);
        fsel    = 0;
        start   = 1'b0;
        m_ready = 1'b1;
        rst     = 1'b1;
        clear_mon();
        repeat (2) tick();

        // Reset values.
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset fn_in", 32'(fn_in), 32'd0);
        chk("reset m_valid", 32'(m_valid), 32'd0);
        chk("reset m_index", 32'(m_index), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        rst = 1'b0;
        tick();

        // Sum-of-minterms function, ready tied high: 16 false + 16 true rows.
        fsel = 0;
        sweep("sdnf", -1, 1'b0);
        check_stream("sdnf", exp16, 48);

        // Truth-table form of the same function.
        fsel = 1;
        sweep("table", -1, 1'b0);
        check_stream("table", exp16, 48);

        // Constant 0: no minterms, one cycle per probe.
        fsel = 2;
        sweep("zero", -1, 1'b0);
        check_stream("zero", exp0, 32);
        chk("zero m_valid never", 32'(vseen), 32'd0);

        // Constant 1: every code is a minterm; count needs the extra bit.
        fsel = 3;
        sweep("ones", -1, 1'b0);
        check_stream("ones", exp32, 64);

        // Backpressure at index 13 holds the stream and stops probing.
        fsel = 0;
        sweep("stall", 13, 1'b0);
        check_stream("stall", exp16, 53);

        // Reset while index 18 is being offered.
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (m_valid && m_index == 5'd18) begin
                    hit = 1'b1;
                    break;
                end
                tick();
            end
            chk("rst reached idx 18", 32'(hit), 32'd1);
        end
        #1 rst = 1'b1;
        #1;
        chk("rst async m_valid", 32'(m_valid), 32'd0);
        chk("rst async m_index", 32'(m_index), 32'd0);
        chk("rst async busy", 32'(busy), 32'd0);
        chk("rst async fn_in", 32'(fn_in), 32'd0);
        chk("rst async count", 32'(count), 32'd0);
        chk("rst async done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst no done pulse", 32'(ndone), 32'd0);
        chk("rst stays idle", 32'(busy), 32'd0);
        sweep("replay", -1, 1'b0);
        check_stream("replay", exp16, 48);

        // Start re-pulsed mid-sweep and in the done cycle is ignored.
        sweep("spam", -1, 1'b1);
        check_stream("spam", exp16, 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
